reset_sequencer: RTL

Parametrised reset sequencer for the spectrum-analyzer PL fabric, sitting between the Zynq PS clock/reset and the downstream processing channels (ADC capture, FFT, magnitude, DMA). It holds all channels in reset after power-on. It then releases them one by one in a staggered order, waits a fixed initialisation delay, and flags the system as running. While running, it supports per-channel soft-reset requests driven from a PS register bitmask, each with its own minimum hold time.

---
 rtl/reset_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: holds every channel in reset, releases them one at a time,
// waits out the init delay, then services per-channel soft-reset requests while running.
module reset_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 32,
  parameter int STAGE_GAP   = 32,
  parameter int INIT_DELAY  = 2000,
  parameter int CNT_W       = 16
) (
  input  logic              ps_clk_i,
  input  logic              ps_rst_i,
  input  logic [NUM_CH-1:0] soft_rst_req_i,
  output logic [NUM_CH-1:0] ch_aresetn_o,
  output logic [NUM_CH-1:0] ch_ready_o,
  output logic              init_done_o,
  output logic [1:0]        seq_state_o
);

  // state   | meaning
  // HOLD    | all channels in reset, counting HOLD_CYCLES
  // RELEASE | releasing channels 1..NUM_CH-1, one every STAGE_GAP cycles
  // INIT    | all channels out of reset, counting INIT_DELAY
  // RUN     | init_done set, soft-reset requests serviced
  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_INIT    = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] INIT_TC = CNT_W'(INIT_DELAY - 1);

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  generate
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
      $error("reset_sequencer: NUM_CH must be within 1..16");
    end
    if (HOLD_CYCLES < 1 || STAGE_GAP < 1 || INIT_DELAY < 1) begin : g_bad_timing
      $error("reset_sequencer: HOLD_CYCLES, STAGE_GAP and INIT_DELAY must be >= 1");
    end
    if (CNT_W < 1 || CNT_W > 62) begin : g_bad_cnt_w
      $error("reset_sequencer: CNT_W out of supported range");
    end
    if (longint'(HOLD_CYCLES) >= longint'(CNT_SPAN) ||
        longint'(STAGE_GAP)   >= longint'(CNT_SPAN) ||
        longint'(INIT_DELAY)  >= longint'(CNT_SPAN)) begin : g_bad_cnt_span
      $error("reset_sequencer: CNT_W too narrow for the configured delays");
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
  logic [NUM_CH-1:0] rel_set;

  logic [NUM_CH-1:0] aresetn_q, aresetn_d;
  logic [NUM_CH-1:0] ready_q, ready_d;
  logic [CNT_W-1:0]  hold_q [NUM_CH];
  logic [CNT_W-1:0]  hold_d [NUM_CH];

  // Sequencing FSM; rel_set flags the channel released at this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = done_q;
    rel_set = '0;
    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_TC) begin
          cnt_d      = '0;
          rel_set[0] = 1'b1;
          if (NUM_CH > 1) begin
            state_d = ST_RELEASE;
            idx_d   = IDX_ONE;
          end else begin
            state_d = ST_INIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == GAP_TC) begin
          cnt_d          = '0;
          rel_set[idx_q] = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_INIT;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_INIT: begin
        if (cnt_q == INIT_TC) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Per-channel reset: sequence releases before RUN, soft-reset hold timers during RUN.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      aresetn_d[i] = aresetn_q[i] | rel_set[i];
      hold_d[i]    = hold_q[i];
      if (state_q == ST_RUN) begin
        if (soft_rst_req_i[i]) begin
          aresetn_d[i] = 1'b0;
          hold_d[i]    = '0;
        end else if (!aresetn_q[i]) begin
          if (hold_q[i] == HOLD_TC) begin
            aresetn_d[i] = 1'b1;
            hold_d[i]    = '0;
          end else begin
            hold_d[i] = hold_q[i] + CNT_ONE;
          end
        end
      end
    end
  end

  // Ready follows reset release by one edge but drops on the same edge as reset.
  assign ready_d = aresetn_q & aresetn_d;

  always_ff @(posedge ps_clk_i) begin
    if (ps_rst_i) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      aresetn_q <= '0;
      ready_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      aresetn_q <= aresetn_d;
      ready_q   <= ready_d;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign ch_aresetn_o = aresetn_q;
  assign ch_ready_o   = ready_q;
  assign init_done_o  = done_q;
  assign seq_state_o  = state_q;

endmodule
